// File: rtl/peg_entry_ctrl_if.sv
// rtl/peg_entry_ctrl_if.sv - keypad, checker, drawer and guess-store signals of the peg entry controller
interface peg_entry_ctrl_if #(
  parameter int COLOR_W = 3
);
  logic [1:0]         key;
  logic [COLOR_W-1:0] color_in;
  logic               draw_done;
  logic               check_done;
  logic               win;
  logic [7:0]         fb_x;
  logic [COLOR_W-1:0] fb_color;
  logic [7:0]         x_out;
  logic [6:0]         y_out;
  logic [COLOR_W-1:0] color_out;
  logic               draw_req;
  logic               peg_we;
  logic [2:0]         peg_idx;
  logic               check_req;
  logic [3:0]         turn;
  logic               game_over;
  logic               win_out;

  // controller side
  modport master (
    input  key, color_in, draw_done, check_done, win, fb_x, fb_color,
    output x_out, y_out, color_out, draw_req, peg_we, peg_idx, check_req,
           turn, game_over, win_out
  );

  // keypad / checker / drawer side
  modport slave (
    output key, color_in, draw_done, check_done, win, fb_x, fb_color,
    input  x_out, y_out, color_out, draw_req, peg_we, peg_idx, check_req,
           turn, game_over, win_out
  );
endinterface

// File: rtl/peg_entry_ctrl.sv
// rtl/peg_entry_ctrl.sv - one Mastermind turn: peg entry/erase, feedback handshake, turn advance
module peg_entry_ctrl #(
  parameter int NUM_PEGS    = 4,
  parameter int NUM_TURNS   = 10,
  parameter int COLOR_W     = 3,
  parameter int X_START     = 38,
  parameter int X_STEP      = 16,
  parameter int Y_START     = 24,
  parameter int Y_STEP      = 6,
  parameter int BLANK_COLOR = 0
) (
  input logic             clk,
  input logic             reset,
  peg_entry_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_ENTRY,
    S_PDRAW,
    S_CHECK,
    S_FBDRAW,
    S_NEXT,
    S_OVER
  } state_t;

  localparam logic [COLOR_W-1:0] BLANK    = COLOR_W'(BLANK_COLOR);
  localparam logic [3:0]         FULL_IDX = 4'(NUM_PEGS);
  localparam logic [3:0]         LAST_TRN = 4'(NUM_TURNS - 1);

  // Slot counter is one bit wider than the peg_idx port so a full row of 8 is representable.
  state_t             state;
  logic [1:0]         key_q;
  logic [3:0]         idx_q;
  logic               placing;
  logic [7:0]         x_q;
  logic [6:0]         y_q;
  logic [COLOR_W-1:0] color_q;
  logic               draw_req_q;
  logic               peg_we_q;
  logic               check_req_q;
  logic [3:0]         turn_q;
  logic               game_over_q;
  logic               win_q;
  logic               key_edge;

  function automatic logic [7:0] peg_x(input logic [3:0] idx);
    return 8'(X_START + int'(idx) * X_STEP);
  endfunction

  // An action fires only when the keypad leaves idle; holding a key never repeats.
  assign key_edge = (key_q == 2'b00) && (bus.key != 2'b00);

  // Turn sequencer: entry, peg draw, feedback check/draw, turn advance, game over.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_ENTRY;
      key_q       <= 2'b00;
      idx_q       <= 4'd0;
      placing     <= 1'b0;
      x_q         <= 8'(X_START);
      color_q     <= '0;
      draw_req_q  <= 1'b0;
      peg_we_q    <= 1'b0;
      check_req_q <= 1'b0;
      turn_q      <= 4'd0;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      key_q       <= bus.key;
      draw_req_q  <= 1'b0;
      peg_we_q    <= 1'b0;
      check_req_q <= 1'b0;
      case (state)
        S_ENTRY: begin
          if (key_edge) begin
            if (bus.key == 2'b01 && idx_q < FULL_IDX) begin
              color_q    <= bus.color_in;
              x_q        <= peg_x(idx_q);
              peg_we_q   <= 1'b1;
              draw_req_q <= 1'b1;
              placing    <= 1'b1;
              state      <= S_PDRAW;
            end else if (bus.key == 2'b10 && idx_q != 4'd0) begin
              idx_q      <= idx_q - 4'd1;
              color_q    <= BLANK;
              x_q        <= peg_x(idx_q - 4'd1);
              draw_req_q <= 1'b1;
              placing    <= 1'b0;
              state      <= S_PDRAW;
            end
          end
        end
        S_PDRAW: begin
          if (bus.draw_done) begin
            if (placing && (idx_q + 4'd1 == FULL_IDX)) begin
              idx_q       <= idx_q + 4'd1;
              check_req_q <= 1'b1;
              state       <= S_CHECK;
            end else begin
              if (placing) idx_q <= idx_q + 4'd1;
              state <= S_ENTRY;
            end
          end
        end
        S_CHECK: begin
          if (bus.check_done) begin
            win_q      <= bus.win;
            x_q        <= bus.fb_x;
            color_q    <= bus.fb_color;
            draw_req_q <= 1'b1;
            state      <= S_FBDRAW;
          end
        end
        S_FBDRAW: begin
          if (bus.draw_done) begin
            if (win_q || turn_q == LAST_TRN) begin
              game_over_q <= 1'b1;
              state       <= S_OVER;
            end else begin
              state <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          turn_q <= turn_q + 4'd1;
          idx_q  <= 4'd0;
          state  <= S_ENTRY;
        end
        S_OVER: begin
          game_over_q <= 1'b1;
        end
        default: state <= S_ENTRY;
      endcase
    end
  end

  // Row y coordinate follows the turn counter one cycle later.
  always_ff @(posedge clk) begin
    if (reset) y_q <= 7'(Y_START);
    else       y_q <= 7'(Y_START + int'(turn_q) * Y_STEP);
  end

  assign bus.x_out     = x_q;
  assign bus.y_out     = y_q;
  assign bus.color_out = color_q;
  assign bus.draw_req  = draw_req_q;
  assign bus.peg_we    = peg_we_q;
  assign bus.peg_idx   = idx_q[2:0];
  assign bus.check_req = check_req_q;
  assign bus.turn      = turn_q;
  assign bus.game_over = game_over_q;
  assign bus.win_out   = win_q;

endmodule

// File: doc/peg_entry_ctrl.md
Name: peg_entry_ctrl

Overview:
- Parametrised successor to the fixed 5-peg board controller.
- Sequences one Mastermind turn: collects NUM_PEGS colour choices from the keypad level code, writes each into the guess store and requests a square draw at the computed screen coordinate.
- Once the row is full, runs a feedback check/draw handshake, then advances the turn.
- Adds a peg erase (backspace) and an explicit game-over state on a win or when turns run out.
- Sits between the keypad decoder, the guess/feedback datapath and the VGA square drawer.

Parameters:
- NUM_PEGS, 4, pegs per guess row (2..8)
- NUM_TURNS, 10, turns before the game is lost (1..15)
- COLOR_W, 3, colour code width
- X_START, 38, x of peg 0 (8-bit)
- X_STEP, 16, x pitch between pegs
- Y_START, 24, y of turn 0 (7-bit)
- Y_STEP, 6, y pitch between turns
- BLANK_COLOR, 0, colour used to erase a peg

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- key  in  2  keypad level code: 00 idle, 01 place, 10 erase, 11 ignored
- color_in  in  COLOR_W  currently selected colour
- draw_done  in  1  one-cycle pulse from drawer: square finished
- check_done  in  1  one-cycle pulse from checker: feedback ready
- win  in  1  checker result, valid in the cycle check_done is high
- fb_x  in  8  feedback x coordinate from checker
- fb_color  in  COLOR_W  feedback colour from checker
- x_out  out  8  draw x coordinate
- y_out  out  7  draw y coordinate
- color_out  out  COLOR_W  draw colour
- draw_req  out  1  one-cycle pulse: start a draw
- peg_we  out  1  one-cycle pulse: write color_out into the guess slot peg_idx
- peg_idx  out  3  current peg slot
- check_req  out  1  one-cycle pulse: start the feedback comparison
- turn  out  4  current turn number
- game_over  out  1  high in OVER
- win_out  out  1  latched win flag

Behaviour:
- Key edge: key_q holds last cycle's key. An action fires only on key_q == 00 && key != 00. Holding a key produces exactly one action. Code 11 is ignored.
- States: ENTRY, PDRAW, CHECK, FBDRAW, NEXT, OVER.
- ENTRY, place action with peg_idx < NUM_PEGS:
  - Register color_out = color_in and x_out = X_START + peg_idx*X_STEP.
  - Pulse peg_we and draw_req in the cycle after the edge.
  - Go to PDRAW with a pending increment.
- ENTRY, erase action with peg_idx > 0:
  - Decrement peg_idx.
  - Register color_out = BLANK_COLOR and x_out for the new index.
  - Pulse draw_req (no peg_we). Go to PDRAW.
- ENTRY, erase action with peg_idx == 0: no effect.
- PDRAW: wait for draw_done. On a place, increment peg_idx. Then:
  - if peg_idx now == NUM_PEGS, go to CHECK and pulse check_req on entry;
  - otherwise return to ENTRY.
- Key edges in PDRAW, CHECK, FBDRAW, NEXT or OVER are discarded; they are not queued.
- CHECK: on check_done, latch win into win_out. Register x_out = fb_x and color_out = fb_color. Pulse draw_req. Go to FBDRAW.
- FBDRAW: on draw_done:
  - if win_out, go to OVER;
  - else if turn == NUM_TURNS-1, go to OVER;
  - else go to NEXT.
- NEXT: one cycle. turn += 1, peg_idx = 0, go to ENTRY.
- OVER: game_over = 1. All request pulses are 0. Only reset leaves this state.
- y_out = Y_START + turn*Y_STEP, registered, and updated in the cycle after turn changes.
- Arithmetic is unsigned. Overflow of x_out/y_out is a parameter error; no run-time check.
- Reset values: state ENTRY, x_out = X_START, y_out = Y_START, color_out = 0, draw_req = 0, peg_we = 0, check_req = 0, peg_idx = 0, turn = 0, game_over = 0, win_out = 0, key_q = 0.
- Reset mid-operation: reset wins over every transition and in-flight handshake. A late draw_done or check_done arriving after reset is ignored in ENTRY.
- Simultaneous draw_done and check_done: only the pulse that is relevant to the current state is acted on.

Test Plan:
- Reset, then key 00→01 with color_in = 5, held 10 cycles → exactly one peg_we/draw_req pulse with x_out = 38, y_out = 24, color_out = 5. After draw_done, peg_idx = 1.
- Place 2 pegs, then erase → draw_req with x_out = 54, color_out = 0, no peg_we. peg_idx returns to 1. A further erase then reaches 0; an erase at peg_idx = 0 produces no pulse.
- Place 4 pegs with draw_done after each → check_req pulse after the 4th draw_done. Then check_done with win = 0, fb_x = 120, fb_color = 2 → draw_req with x_out = 120, color_out = 2. After draw_done: turn = 1, y_out = 30, peg_idx = 0.
- Turn 3: check_done with win = 1, then draw_done → game_over = 1, win_out = 1. Subsequent key edges produce no pulses.
- Ten non-winning turns → after the final feedback draw_done, game_over = 1, win_out = 0, turn = 9.
- Assert reset while in PDRAW with peg_idx = 2, then deliver draw_done → all outputs at reset values and peg_idx stays 0.
